// File: rtl/rst_seq_pkg.sv
// rst_seq shared types: FSM state encoding and counter-width helper.
// Imported by rst_seq and rst_seq_ch.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ch.sv
// rst_seq_ch: one reset channel: soft-reset countdown plus its rst_out bit.
// Ports: clk, rst (global hold), en_run, req, release_now -> rst_out.
module rst_seq_ch
  import rst_seq_pkg::*;
#(
  parameter int MIN_ASSERT = 8,
  parameter int CW         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_run,
  input  logic req,
  input  logic release_now,
  output logic rst_out
);

  localparam logic [CW-1:0] LOAD = CW'(MIN_ASSERT - 1);

  logic          rst_q, rst_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rst_d = rst_q;
    cnt_d = cnt_q;
    if (en_run && req) begin
      rst_d = 1'b1;
      cnt_d = LOAD;
    end else if (release_now) begin
      rst_d = 1'b0;
    end else if (en_run && rst_q) begin
      // in RUN a set bit can only be a soft reset in progress
      if (cnt_q == '0) rst_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      rst_q <= rst_d;
      cnt_q <= cnt_d;
    end
  end

  assign rst_out = rst_q;

endmodule

// File: rtl/rst_seq.sv
// rst_seq: global reset sequencer with staggered per-channel release.
// Ports: clk, rst, glb_req, ch_req -> rst_out[NUM_CH], rst_done.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int MIN_ASSERT = 8,
  parameter int STAGE_DLY  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              glb_req,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              rst_done
);

  localparam int CW = cnt_w(MIN_ASSERT, STAGE_DLY);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] MA    = CW'(MIN_ASSERT);
  localparam logic [CW-1:0] SD_M1 = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] LAST  = IW'(NUM_CH - 1);
  localparam bit            ONE   = (NUM_CH == 1);

  logic          hold;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic [NUM_CH-1:0] rel;

  assign hold = rst | glb_req;

  always_comb begin
    rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == ST_ASSERT && cnt_q == MA && i == 0)
        rel[i] = 1'b1;
      if (state_q == ST_RELEASE && cnt_q == SD_M1 &&
          idx_q == IW'(i))
        rel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == MA) begin
            cnt_q <= '0;
            if (ONE) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              idx_q   <= IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == SD_M1) begin
            cnt_q <= '0;
            if (idx_q == LAST) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ASSERT;
          cnt_q   <= '0;
          idx_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rst_seq_ch #(
      .MIN_ASSERT (MIN_ASSERT),
      .CW         (CW)
    ) u_ch (
      .clk         (clk),
      .rst         (hold),
      .en_run      (state_q == ST_RUN),
      .req         (ch_req[g]),
      .release_now (rel[g]),
      .rst_out     (rst_out[g])
    );
  end

  assign rst_done = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed self-checking bench for rst_seq.
// Defaults NUM_CH=4, MIN_ASSERT=8, STAGE_DLY=16.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       glb_req = 1'b0;
  logic [3:0] ch_req = 4'h0;
  logic [3:0] rst_out;
  logic       rst_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_CH     (4),
    .MIN_ASSERT (8),
    .STAGE_DLY  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .glb_req  (glb_req),
    .ch_req   (ch_req),
    .rst_out  (rst_out),
    .rst_done (rst_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected outputs after edge e of a release sequence
  function automatic logic [3:0] exp_out(input int e);
    if (e < 8)  return 4'hF;
    if (e < 24) return 4'hE;
    if (e < 40) return 4'hC;
    if (e < 56) return 4'h8;
    return 4'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_chk++;
    if (rst_out !== 4'hF || rst_done !== 1'b0)
      $display("FAIL reset rst_out=%h done=%b exp=F/0",
               rst_out, rst_done);
    else n_pass++;
  endtask

  task automatic test_power_on();
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      tick();
      n_chk++;
      if (rst_out !== exp_out(e) || rst_done !== (e >= 56))
        $display("FAIL power_on e=%0d rst_out=%h done=%b exp=%h/%b",
                 e, rst_out, rst_done, exp_out(e), e >= 56);
      else n_pass++;
    end
  endtask

  task automatic test_glb_req();
    glb_req = 1'b1;
    tick();
    glb_req = 1'b0;
    n_chk++;
    if (rst_out !== 4'hF || rst_done !== 1'b0)
      $display("FAIL glb_hold rst_out=%h done=%b exp=F/0",
               rst_out, rst_done);
    else n_pass++;
    for (int e = 0; e <= 60; e++) begin
      tick();
      n_chk++;
      if (rst_out !== exp_out(e) || rst_done !== (e >= 56))
        $display("FAIL glb_seq e=%0d rst_out=%h done=%b exp=%h/%b",
                 e, rst_out, rst_done, exp_out(e), e >= 56);
      else n_pass++;
    end
  endtask

  task automatic test_soft();
    logic [3:0] ex;
    ch_req = 4'b0100;
    tick();
    ch_req = 4'h0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) tick();
      ex = (j < 8) ? 4'h4 : 4'h0;
      n_chk++;
      if (rst_out !== ex || rst_done !== 1'b1)
        $display("FAIL soft j=%0d rst_out=%h done=%b exp=%h/1",
                 j, rst_out, rst_done, ex);
      else n_pass++;
    end
  endtask

  task automatic test_extend();
    logic [3:0] ex;
    for (int j = 0; j <= 15; j++) begin
      if (j == 0 || j == 5) ch_req = 4'b0100;
      else if (j == 2)      ch_req = 4'b0001;
      else                  ch_req = 4'b0000;
      tick();
      ex = 4'h0;
      ex[2] = (j < 13);
      ex[0] = (j >= 2 && j < 10);
      n_chk++;
      if (rst_out !== ex || rst_done !== 1'b1)
        $display("FAIL extend j=%0d rst_out=%h done=%b exp=%h/1",
                 j, rst_out, rst_done, ex);
      else n_pass++;
    end
    ch_req = 4'h0;
  endtask

  task automatic test_ignored();
    glb_req = 1'b1;
    tick();
    glb_req = 1'b0;
    for (int e = 0; e <= 60; e++) begin
      ch_req = (e == 30) ? 4'hF : 4'h0;
      tick();
      n_chk++;
      if (rst_out !== exp_out(e) || rst_done !== (e >= 56))
        $display("FAIL ignored e=%0d rst_out=%h done=%b exp=%h/%b",
                 e, rst_out, rst_done, exp_out(e), e >= 56);
      else n_pass++;
    end
    ch_req = 4'h0;
  endtask

  task automatic test_priority();
    glb_req = 1'b1;
    ch_req  = 4'b0010;
    tick();
    glb_req = 1'b0;
    ch_req  = 4'h0;
    n_chk++;
    if (rst_out !== 4'hF || rst_done !== 1'b0)
      $display("FAIL prio_hold rst_out=%h done=%b exp=F/0",
               rst_out, rst_done);
    else n_pass++;
    for (int e = 0; e <= 70; e++) begin
      tick();
      n_chk++;
      if (rst_out !== exp_out(e) || rst_done !== (e >= 56))
        $display("FAIL prio_seq e=%0d rst_out=%h done=%b exp=%h/%b",
                 e, rst_out, rst_done, exp_out(e), e >= 56);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    glb_req = 1'b1;
    tick();
    glb_req = 1'b0;
    for (int e = 0; e < 30; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (rst_out !== 4'hF || rst_done !== 1'b0)
      $display("FAIL mid_hold rst_out=%h done=%b exp=F/0",
               rst_out, rst_done);
    else n_pass++;
    for (int e = 0; e <= 60; e++) begin
      tick();
      n_chk++;
      if (rst_out !== exp_out(e) || rst_done !== (e >= 56))
        $display("FAIL mid_seq e=%0d rst_out=%h done=%b exp=%h/%b",
                 e, rst_out, rst_done, exp_out(e), e >= 56);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft();
    test_extend();
    test_glb_req();
    test_ignored();
    test_priority();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
